// File: rtl/whiz_line_scheduler.sv
// Scanline timing controller: walks OAM/transfer/HBlank/VBlank per dot, hands each
// visible line to the renderer and raises the LCD interrupt pulses.
module whiz_line_scheduler #(
  parameter int unsigned DOTS_PER_LINE = 456,
  parameter int unsigned OAM_DOTS      = 80,
  parameter int unsigned MIN_XFER_DOTS = 172,
  parameter int unsigned VISIBLE_LINES = 144,
  parameter int unsigned TOTAL_LINES   = 154
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dot_tick,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_int_en,
  input  logic       renderComplete,
  output logic       drawline,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       render_overrun
);

  localparam int unsigned DOT_W = $clog2(DOTS_PER_LINE);
  localparam int unsigned LY_W  = 8;

  localparam logic [DOT_W-1:0] DOT_LAST      = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0] OAM_LAST      = DOT_W'(OAM_DOTS - 1);
  localparam logic [DOT_W-1:0] XFER_MIN_LAST = DOT_W'(OAM_DOTS + MIN_XFER_DOTS - 1);
  localparam logic [LY_W-1:0]  LY_LAST       = LY_W'(TOTAL_LINES - 1);
  localparam logic [LY_W-1:0]  LY_VBLANK     = LY_W'(VISIBLE_LINES);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_OAM,
    ST_XFER,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  state_t           state;
  logic [DOT_W-1:0] dot;
  logic             render_done;
  logic             stat_prev;
  logic             stat_line_c;
  logic [LY_W-1:0]  ly_next_c;

  // Combined STAT request; a new source joining an already-high line adds no edge.
  always_comb begin
    stat_line_c = (state != ST_OFF) &
                  ((stat_int_en[0] & (mode == MODE_HBLANK)) |
                   (stat_int_en[1] & (mode == MODE_VBLANK)) |
                   (stat_int_en[2] & (mode == MODE_OAM))    |
                   (stat_int_en[3] & lyc_match));
  end

  always_comb begin
    ly_next_c = (ly == LY_LAST) ? '0 : ly + LY_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_OFF;
      dot            <= '0;
      ly             <= '0;
      mode           <= MODE_HBLANK;
      drawline       <= 1'b0;
      lyc_match      <= 1'b0;
      vblank_irq     <= 1'b0;
      stat_irq       <= 1'b0;
      render_overrun <= 1'b0;
      render_done    <= 1'b0;
      stat_prev      <= 1'b0;
    end else begin
      drawline   <= 1'b0;
      vblank_irq <= 1'b0;
      stat_irq   <= 1'b0;

      if (!lcd_enable) begin
        // Disabling the LCD aborts whatever is in flight, including a transfer.
        state       <= ST_OFF;
        dot         <= '0;
        ly          <= '0;
        mode        <= MODE_HBLANK;
        lyc_match   <= 1'b0;
        render_done <= 1'b0;
        stat_prev   <= 1'b0;
      end else begin
        lyc_match <= (state != ST_OFF) && (ly == lyc);
        stat_prev <= stat_line_c;
        stat_irq  <= stat_line_c & ~stat_prev;

        // The drawline clk itself is excluded so a stale completion level is not taken.
        if ((state == ST_XFER) && !drawline && renderComplete) begin
          render_done <= 1'b1;
        end

        case (state)
          ST_OFF: begin
            state <= ST_OAM;
            dot   <= '0;
            ly    <= '0;
            mode  <= MODE_OAM;
          end
          default: begin
            if (dot_tick) begin
              if (dot == DOT_LAST) begin
                if ((state == ST_XFER) && !render_done) begin
                  render_overrun <= 1'b1;
                end
                dot         <= '0;
                ly          <= ly_next_c;
                render_done <= 1'b0;
                if (ly_next_c < LY_VBLANK) begin
                  state <= ST_OAM;
                  mode  <= MODE_OAM;
                end else begin
                  state <= ST_VBLANK;
                  mode  <= MODE_VBLANK;
                  if (state != ST_VBLANK) begin
                    vblank_irq <= 1'b1;
                  end
                end
              end else begin
                dot <= dot + DOT_W'(1);
                if ((state == ST_OAM) && (dot == OAM_LAST)) begin
                  state    <= ST_XFER;
                  mode     <= MODE_XFER;
                  drawline <= 1'b1;
                end else if ((state == ST_XFER) && render_done && (dot >= XFER_MIN_LAST)) begin
                  state <= ST_HBLANK;
                  mode  <= MODE_HBLANK;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/whiz_line_scheduler.md
Name: whiz_line_scheduler

Overview:
- Scanline timing controller for the whizgraphics renderer.
- Counts dots and lines and walks the LCD through modes: OAM search, transfer, HBlank and VBlank.
- Once per visible line, pulses drawline to the renderer and waits for renderComplete.
- Publishes LY, mode, the LYC match flag, and the VBlank and STAT interrupt pulses consumed by the interrupt controller and the STAT/LY registers on the DataBus.

Parameters:
- DOTS_PER_LINE, 456, dots per scanline; dot counter wraps at DOTS_PER_LINE-1.
- OAM_DOTS, 80, length of mode 2 in dots.
- MIN_XFER_DOTS, 172, minimum length of mode 3 in dots.
- VISIBLE_LINES, 144, number of lines that are rendered.
- TOTAL_LINES, 154, lines per frame including VBlank.

Ports:
- clk in 1: system clock.
- rst_n in 1: reset, asynchronous, active-low.
- dot_tick in 1: dot clock enable; all counters advance only on cycles where dot_tick=1.
- lcd_enable in 1: LCDC bit 7.
- lyc in 8: LY compare value.
- stat_int_en in 4: STAT enables. Bit 0 = HBlank, bit 1 = VBlank, bit 2 = OAM, bit 3 = LYC.
- renderComplete in 1: renderer finished the current line (level).
- drawline out 1: single-clk pulse that starts rendering of line ly.
- ly out 8: current line.
- mode out 2: 0 = HBlank/off, 1 = VBlank, 2 = OAM, 3 = transfer.
- lyc_match out 1: high when ly==lyc and the LCD is enabled.
- vblank_irq out 1: single-clk pulse.
- stat_irq out 1: single-clk pulse.
- render_overrun out 1: sticky error flag.

Behaviour:
- Reset values:
  - State OFF.
  - dot counter = 0, ly = 0, mode = 0.
  - drawline, lyc_match, vblank_irq, stat_irq, render_overrun all 0.
  - render_done latch = 0.
- States: OFF, OAM (mode 2), XFER (mode 3), HBLANK (mode 0), VBLANK (mode 1).
- OFF:
  - ly=0, dot=0, mode=0, no pulses.
  - Any state moves to OFF on the first clk where lcd_enable=0. This is an immediate abort, even mid-XFER, and clears render_done.
  - OFF moves to OAM (ly=0, dot=0) on the first clk with lcd_enable=1.
- Dot counter:
  - Increments on dot_tick.
  - At DOTS_PER_LINE-1 with dot_tick, it wraps to 0 and ly increments.
  - ly wraps from TOTAL_LINES-1 to 0.
- OAM:
  - On the dot_tick where dot==OAM_DOTS-1, the next state is XFER with dot=OAM_DOTS.
  - drawline=1 for exactly the one clk in which the state register first holds XFER.
- XFER:
  - render_done is set when renderComplete=1 on any clk after the drawline pulse clk. renderComplete is ignored in all other states.
  - Moves to HBLANK on the first dot_tick where render_done=1 and dot >= OAM_DOTS+MIN_XFER_DOTS-1. The next dot then reads OAM_DOTS+MIN_XFER_DOTS or later.
- Overrun:
  - If XFER reaches the line-end dot_tick (dot==DOTS_PER_LINE-1) without render_done, render_overrun is set (sticky until rst_n) and the line advances normally.
  - render_done clears on every line advance.
- HBLANK:
  - At line end, the next line enters OAM if the new ly < VISIBLE_LINES.
  - Otherwise it enters VBLANK, and vblank_irq pulses for the one clk in which the state first holds VBLANK.
- VBLANK:
  - Lines VISIBLE_LINES..TOTAL_LINES-1, with no drawline.
  - After line TOTAL_LINES-1, moves to OAM with ly=0.
- lyc_match: registered compare of ly and lyc, updated every clk. Forced 0 in OFF.
- STAT line:
  - Internal signal, OR of:
    - (en0 & mode==0 & state!=OFF)
    - (en1 & mode==1)
    - (en2 & mode==2)
    - (en3 & lyc_match)
  - stat_irq pulses one clk on a 0→1 edge of the STAT line only. When one condition is already holding the line high, a second condition becoming true produces no new pulse.
  - The STAT line is held 0 in OFF.
- dot_tick=0: all state, counters and outputs hold, except:
  - the single-clk pulses deassert,
  - the render_done latch still samples renderComplete.
- Simultaneous events:
  - lcd_enable=0 wins over every transition.
  - If renderComplete and the line-end tick arrive on the same clk, render_done is not yet registered, so overrun is flagged.

Test Plan:
- dot_tick=1 constantly, lcd_enable rises at t0, renderComplete goes high 10 clks after drawline → drawline at the dot-80 clk; mode 2→3→0 at dots 80 and 252; ly=1 after 456 clks.
- renderComplete goes high 200 dots after drawline → mode 3 lasts 200 or 201 dots; HBlank starts at about dot 281; render_overrun stays 0.
- renderComplete is never asserted → render_overrun=1 at the end of line 0; ly=1; OAM starts; a new drawline fires at dot 80.
- Run a full frame → exactly 144 drawline pulses; one vblank_irq as ly goes to 144; ly wraps from 153 to 0 after 70224 dot_ticks.
- lyc=5, stat_int_en=4'b1000 → lyc_match is high throughout line 5 and stat_irq pulses once. Then enable bit 0 as well → no extra pulse at the HBlank of line 5 (line already high); a pulse at the HBlank of line 6.
- Drop lcd_enable mid-XFER on line 3, or assert rst_n=0 asynchronously → ly=0, mode=0, drawline=0 immediately. Re-enable → OAM on line 0, with the next drawline 80 dots later.
